fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fq_pkg.sv | 14 +
 rtl/fq_compact.sv | 18 +
 rtl/fetch_queue.sv | 123 ++++++++++++
 tb/tb_fetch_queue.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/fq_pkg.sv
// Shared types and widths for the fetch queue.
package fq_pkg;
  localparam int FETCH_W = 8;   // lanes per fetch bundle
  localparam int INST_W  = 32;
  localparam int PC_W    = 64;
  localparam int OFF_W   = 3;   // per-lane write offset, 0..FETCH_W-1
  localparam int CNT_W   = 4;   // lanes kept per bundle, 0..FETCH_W

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
    logic              bp;
  } fq_entry_t;
endpackage

// File: rtl/fq_compact.sv
// Mask compaction: each kept lane's write offset is the number of kept
// lanes below it (prefix popcount); enq_n is the total kept.
module fq_compact
  import fq_pkg::*;
(
  input  logic [FETCH_W-1:0]            mask_i,
  output logic [FETCH_W-1:0][OFF_W-1:0] off_o,
  output logic [CNT_W-1:0]              enq_n_o
);
  logic [FETCH_W:0][CNT_W-1:0] pre;

  assign pre[0] = '0;
  for (genvar k = 0; k < FETCH_W; k++) begin : g_lane
    assign pre[k+1]  = pre[k] + CNT_W'(mask_i[k]);
    assign off_o[k]  = pre[k][OFF_W-1:0];
  end
  assign enq_n_o = pre[FETCH_W];
endmodule

// File: rtl/fetch_queue.sv
// Fetch queue: compacts masked 8-lane fetch bundles into a circular buffer
// and presents up to DEQ_W instructions per cycle to decode.
// Optional statistics counters are built when FETCH_QUEUE_STATS_EN is defined.
module fetch_queue
  import fq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DEQ_W = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [PC_W-1:0]           in_pc,
  input  logic [FETCH_W*INST_W-1:0] in_data,
  input  logic [FETCH_W-1:0]        in_mask,
  input  logic [FETCH_W-1:0]        in_bp,
  output logic                      in_ready,
  output logic [DEQ_W-1:0]          out_valid,
  output logic [DEQ_W*INST_W-1:0]   out_inst,
  output logic [DEQ_W*PC_W-1:0]     out_pc,
  output logic [DEQ_W-1:0]          out_bp,
  input  logic                      out_ready,
  input  logic                      flush
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [31:0]               stat_stall_cnt,
  output logic [15:0]               stat_flush_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fq_entry_t mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d, deq_n;
  logic [FETCH_W-1:0][OFF_W-1:0] off;
  logic [CNT_W-1:0] enq_n;
  logic enq_fire, deq_fire;

  fq_compact u_compact (
    .mask_i  (in_mask),
    .off_o   (off),
    .enq_n_o (enq_n)
  );

  // Ready depends only on registered occupancy so upstream never sees a
  // combinational path from decode's out_ready.
  assign in_ready = (CW'(DEPTH) - count_q) >= CW'(FETCH_W);
  assign deq_n    = (count_q < CW'(DEQ_W)) ? count_q : CW'(DEQ_W);
  assign enq_fire = in_valid && in_ready && !flush;
  assign deq_fire = out_ready && (deq_n != '0) && !flush;

  // Issue slots read straight from storage starting at head.
  for (genvar j = 0; j < DEQ_W; j++) begin : g_slot
    fq_entry_t e;
    assign e = mem_q[head_q + AW'(j)];
    assign out_valid[j]              = CW'(j) < deq_n;
    assign out_inst[j*INST_W +: INST_W] = e.inst;
    assign out_pc[j*PC_W +: PC_W]       = e.pc;
    assign out_bp[j]                    = e.bp;
  end

  // Pointer/occupancy next state; flush overrides both transfers.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq_fire) tail_d = tail_q + AW'(enq_n);
      if (deq_fire) head_d = head_q + AW'(deq_n);
      count_d = count_q + (enq_fire ? CW'(enq_n) : CW'(0))
                        - (deq_fire ? deq_n : CW'(0));
    end
  end

  // Control state, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage has no reset; only kept lanes are written, packed from tail.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      for (int k = 0; k < FETCH_W; k++) begin
        if (in_mask[k])
          mem_q[tail_q + AW'(off[k])] <= '{inst: in_data[k*INST_W +: INST_W],
                                           pc:   in_pc + PC_W'(4*k),
                                           bp:   in_bp[k]};
      end
    end
  end

`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] stall_q;
  logic [15:0] flush_q;

  // Saturating stall/flush event counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (in_valid && !in_ready && stall_q != '1) stall_q <= stall_q + 32'd1;
      if (flush && flush_q != '1)                 flush_q <= flush_q + 16'd1;
    end
  end

  assign stat_stall_cnt = stall_q;
  assign stat_flush_cnt = flush_q;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: randomized bundles against a queue-based model,
// scoreboard checked by a monitor every cycle, plus directed corner cases.
module tb_fetch_queue;
  import fq_pkg::*;
  localparam int DEPTH = 16;
  localparam int DEQ_W = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic [63:0] in_pc = '0;
  logic [255:0] in_data = '0;
  logic [7:0] in_mask = '0, in_bp = '0;
  logic in_ready;
  logic [DEQ_W-1:0] out_valid, out_bp;
  logic [DEQ_W*32-1:0] out_inst;
  logic [DEQ_W*64-1:0] out_pc;
  logic out_ready = 1'b0, flush = 1'b0;
`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] stat_stall_cnt;
  logic [15:0] stat_flush_cnt;
`endif

  fetch_queue #(.DEPTH(DEPTH), .DEQ_W(DEQ_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc),
    .in_data(in_data), .in_mask(in_mask), .in_bp(in_bp), .in_ready(in_ready),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc), .out_bp(out_bp),
    .out_ready(out_ready), .flush(flush)
`ifdef FETCH_QUEUE_STATS_EN
    , .stat_stall_cnt(stat_stall_cnt), .stat_flush_cnt(stat_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] inst; logic [63:0] pc; logic bp; } exp_t;
  exp_t exp_q[$];   // model contents, oldest first
  exp_t pend_q[$];  // entries the current cycle's bundle will add

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus; queue the expected entries if it will enqueue.
  task automatic drive(input bit v, input logic [63:0] pc, input logic [255:0] d,
                       input logic [7:0] m, input logic [7:0] b,
                       input bit ordy, input bit fl, input bit rst_n);
    @(posedge clk); #2;
    reset = rst_n; in_valid = v; in_pc = pc; in_data = d;
    in_mask = m; in_bp = b; out_ready = ordy; flush = fl;
    if (rst_n && v && !fl && (DEPTH - exp_q.size() >= 8))
      for (int k = 0; k < 8; k++)
        if (m[k]) pend_q.push_back('{d[32*k +: 32], pc + 64'(4*k), b[k]});
  endtask

  task automatic idle(input bit ordy);
    drive(1'b0, 64'h0, 256'h0, 8'h00, 8'h00, ordy, 1'b0, 1'b1);
  endtask

  function automatic logic [255:0] rnd_data();
    logic [255:0] d;
    for (int k = 0; k < 8; k++) d[32*k +: 32] = $urandom;
    return d;
  endfunction

  // Monitor: compare DUT outputs with the model, then advance the model.
  initial begin
    int n;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        exp_q.delete();
        pend_q.delete();
      end else begin
        n = (exp_q.size() < DEQ_W) ? exp_q.size() : DEQ_W;
        chk("in_ready", 64'(in_ready), 64'((DEPTH - exp_q.size()) >= 8));
        chk("out_valid", 64'(out_valid), 64'((1 << n) - 1));
        for (int j = 0; j < n; j++) begin
          chk("out_inst", 64'(out_inst[32*j +: 32]), 64'(exp_q[j].inst));
          chk("out_pc", out_pc[64*j +: 64], exp_q[j].pc);
          chk("out_bp", 64'(out_bp[j]), 64'(exp_q[j].bp));
        end
        if (flush) begin
          exp_q.delete();
          pend_q.delete();
        end else begin
          if (out_ready) repeat (n) void'(exp_q.pop_front());
          while (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [255:0] d;
    // Reset held for a couple of cycles.
    drive(1'b0, 64'h0, 256'h0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    idle(1'b0);

    // Full bundle into empty queue.
    d = rnd_data();
    drive(1'b1, 64'h1000, d, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    @(negedge clk); #1;
    chk("d_full_valid", 64'(out_valid), 64'hF);
    chk("d_full_pc0", out_pc[63:0], 64'h1000);
    chk("d_full_pc3", out_pc[255:192], 64'h100C);

    // Mask with a hole in lane 0.
    drive(1'b0, 64'h0, 256'h0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 64'h2000, rnd_data(), 8'hFE, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    @(negedge clk); #1;
    chk("d_hole_pc0", out_pc[63:0], 64'h2004);

    // Reach count 10, then upstream is back-pressured.
    drive(1'b1, 64'h3000, rnd_data(), 8'h07, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    @(negedge clk); #1;
    chk("d_full_ready", 64'(in_ready), 64'd0);
    repeat (3) drive(1'b1, 64'h4000, rnd_data(), 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
`ifdef FETCH_QUEUE_STATS_EN
    @(negedge clk); #1;
    chk("d_stall_cnt", 64'(stat_stall_cnt), 64'd3);
    chk("d_flush_cnt", 64'(stat_flush_cnt), 64'd1);
`endif

    // Flush beats a simultaneous enqueue and dequeue.
    drive(1'b1, 64'h5000, rnd_data(), 8'hFF, 8'h00, 1'b1, 1'b1, 1'b1);
    idle(1'b0);
    @(negedge clk); #1;
    chk("d_flush_valid", 64'(out_valid), 64'd0);
    chk("d_flush_ready", 64'(in_ready), 64'd1);

    // Two entries, bp on lane 1, drained in one cycle.
    drive(1'b1, 64'h6000, rnd_data(), 8'h03, 8'h02, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    @(negedge clk); #1;
    chk("d_two_valid", 64'(out_valid), 64'h3);
    chk("d_two_bp1", 64'(out_bp[1]), 64'd1);
    idle(1'b1);
    idle(1'b0);
    @(negedge clk); #1;
    chk("d_drain_valid", 64'(out_valid), 64'd0);

    // Random traffic: wraps, partial masks, stalls, occasional flush/reset.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] m;
      case ($urandom_range(0, 5))
        0: m = 8'hFF;
        1: m = 8'h00;
        default: m = 8'($urandom);
      endcase
      drive(($urandom % 4) != 0, {$urandom, $urandom}, rnd_data(), m, 8'($urandom),
            ($urandom % 3) != 0, ($urandom % 50) == 0, ($urandom % 250) != 0);
    end
    idle(1'b0);
    @(negedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
